// File: rtl/rx_frame_ctrl_if.sv
// Output word channel of rx_frame_ctrl: a one-entry register drained by the consumer.
// A word transfers on a rising edge where out_valid and out_ready are both 1; out_data is stable while out_valid is high.
interface rx_frame_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Frame controller for a one-bit-per-clock serial receiver: start, DATA_W data bits LSB first, parity, stop.
// Define RX_ERRCNT_EN to add the 8-bit saturating err_count output.
module rx_frame_ctrl #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    rx_frame_ctrl_if.master   out_if,
    output logic [DATA_W-1:0] leds,
    output logic              busy,
    output logic              parity_err,
    output logic              stop_err,
    output logic              overrun,
`ifdef RX_ERRCNT_EN
    output logic [7:0]        err_count,
`endif
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    state_e            state_q,      state_d;
    logic [IDX_W-1:0]  bit_idx_q,    bit_idx_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic              pbit_q,       pbit_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] leds_q,       leds_d;
    logic              parity_err_q, parity_err_d;
    logic              stop_err_q,   stop_err_d;
    logic              overrun_q,    overrun_d;
`ifdef RX_ERRCNT_EN
    logic [7:0]        err_count_q,  err_count_d;
`endif

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        pbit_d       = pbit_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        leds_d       = leds_q;
        parity_err_d = 1'b0;
        stop_err_d   = 1'b0;
        overrun_d    = 1'b0;

        // A consumer transfer empties the register unless a new word lands on the same edge.
        if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (bit_idx_q == IDX_W'(i)) begin
                        shift_d[i] = rx;
                    end
                end
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (bit_idx_q == LAST_IDX) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                pbit_d  = rx;
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                if (!rx) begin
                    stop_err_d = 1'b1;
                end else if ((^shift_q ^ pbit_q) != PARITY_ODD) begin
                    parity_err_d = 1'b1;
                    leds_d       = '1;
                end else begin
                    // LEDs show every good word, even one lost to a full output register.
                    leds_d = shift_q;
                    if (!out_valid_q || out_if.out_ready) begin
                        out_data_d  = shift_q;
                        out_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RX_ERRCNT_EN
    always_comb begin
        err_count_d = err_count_q;
        if ((parity_err_d || stop_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            pbit_q       <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            leds_q       <= '0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef RX_ERRCNT_EN
            err_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            pbit_q       <= pbit_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            leds_q       <= leds_d;
            parity_err_q <= parity_err_d;
            stop_err_q   <= stop_err_d;
            overrun_q    <= overrun_d;
`ifdef RX_ERRCNT_EN
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign leds             = leds_q;
    assign busy             = (state_q != IDLE);
    assign parity_err       = parity_err_q;
    assign stop_err         = stop_err_q;
    assign overrun          = overrun_q;
    assign dbg_state        = state_q;
`ifdef RX_ERRCNT_EN
    assign err_count        = err_count_q;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl (DATA_W=8, even parity); delivered words are checked against an expected queue.
module tb_rx_frame_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx;
    logic [W-1:0] leds;
    logic         busy;
    logic         parity_err;
    logic         stop_err;
    logic         overrun;
    logic [1:0]   dbg_state;
`ifdef RX_ERRCNT_EN
    logic [7:0]   err_count;
`endif

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    rx_frame_ctrl_if #(.DATA_W(W)) bus ();

    rx_frame_ctrl #(.DATA_W(W), .PARITY_ODD(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .out_if     (bus),
        .leds       (leds),
        .busy       (busy),
        .parity_err (parity_err),
        .stop_err   (stop_err),
        .overrun    (overrun),
`ifdef RX_ERRCNT_EN
        .err_count  (err_count),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drivers: inputs change 1 time unit after the rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        rx = 1'b1;
    endtask

    // Monitor: every transfer on the output channel pops one expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_word: got %0h expected no transfer", bus.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_word", {24'd0, bus.out_data}, {24'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        rx            = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_leds", {24'd0, leds}, 32'd0);
        rst_n = 1'b1;

        // Good frame, consumer ready
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_out_data", {24'd0, bus.out_data}, 32'hA5);
        check("t1_leds", {24'd0, leds}, 32'hA5);
        check("t1_errs", {29'd0, parity_err, stop_err, overrun}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        drive_bit(1'b1);
        check("t1_valid_drained", {31'd0, bus.out_valid}, 32'd0);

        // Parity error
        send_frame(8'h01, 1'b0, 1'b1);
        check("t2_parity_err", {31'd0, parity_err}, 32'd1);
        check("t2_stop_err", {31'd0, stop_err}, 32'd0);
        check("t2_leds", {24'd0, leds}, 32'hFF);
        check("t2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t2_out_data", {24'd0, bus.out_data}, 32'hA5);
`ifdef RX_ERRCNT_EN
        check("t2_err_count", {24'd0, err_count}, 32'd1);
`endif
        drive_bit(1'b1);
        check("t2_pulse_end", {31'd0, parity_err}, 32'd0);

        // Stop-bit error
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t3_stop_err", {31'd0, stop_err}, 32'd1);
        check("t3_parity_err", {31'd0, parity_err}, 32'd0);
        check("t3_leds", {24'd0, leds}, 32'hFF);
        check("t3_out_data", {24'd0, bus.out_data}, 32'hA5);
        check("t3_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef RX_ERRCNT_EN
        check("t3_err_count", {24'd0, err_count}, 32'd2);
`endif
        drive_bit(1'b1);
        check("t3_pulse_end", {31'd0, stop_err}, 32'd0);

        // Back-to-back frames into a stalled consumer
        bus.out_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1);
        check("t4a_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t4a_out_data", {24'd0, bus.out_data}, 32'h11);
        check("t4a_overrun", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1);
        check("t4b_overrun", {31'd0, overrun}, 32'd1);
        check("t4b_out_data", {24'd0, bus.out_data}, 32'h11);
        check("t4b_leds", {24'd0, leds}, 32'h22);
        check("t4b_out_valid", {31'd0, bus.out_valid}, 32'd1);
        drive_bit(1'b1);
        check("t4_overrun_end", {31'd0, overrun}, 32'd0);
        check("t4_valid_held", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_fall", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_state", {30'd0, dbg_state}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_out_data", {24'd0, bus.out_data}, 32'd0);
        check("t5_leds", {24'd0, leds}, 32'd0);
`ifdef RX_ERRCNT_EN
        check("t5_err_count", {24'd0, err_count}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rx    = 1'b1;
        rst_n = 1'b1;
        drive_bit(1'b1);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b0, 1'b1);
        check("t5_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t5_new_data", {24'd0, bus.out_data}, 32'h7E);
        check("t5_new_leds", {24'd0, leds}, 32'h7E);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("exp_q_empty", exp_q.size(), 32'd0);

`ifdef RX_ERRCNT_EN
        // Saturation of the error counter
        for (int n = 0; n < 300; n++) send_frame(8'h01, 1'b0, 1'b1);
        drive_bit(1'b1);
        check("err_count_sat", {24'd0, err_count}, 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
